// File: rtl/pnr_bus_pkg.sv
// Shared state type, timeout default and PNR register map for the PNR bus master.
package pnr_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    RESP
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  localparam logic [31:0] PNR_FIFO_DATA  = 32'h0000_0070;
  localparam logic [31:0] PNR_FIFO_COUNT = 32'h0000_0074;
  localparam logic [31:0] PNR_FIFO_RESET = 32'h0000_0078;

  // Writes always take one beat; a read burst of 0 is treated as 1.
  function automatic logic [15:0] beat_count(input logic we, input logic [15:0] burst);
    if (we || burst == 16'd0) begin
      return 16'd1;
    end
    return burst;
  endfunction

endpackage

// File: rtl/pnr_bus_watchdog.sv
// Ack timeout counter: cleared on strobe, counts while waiting, flags expiry on the
// last permitted waiting cycle.
module pnr_bus_watchdog
  import pnr_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic i_clear,
  input  logic i_start,
  output logic o_expired
);

  logic [15:0] r_count;

  assign o_expired = i_start && (r_count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_start && !o_expired) begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: rtl/pnr_bus_master.sv
// Command/response to simple strobe-ack bus master with same-address read bursts.
// Optional ack timeout is enabled by defining PNR_BUS_TIMEOUT_EN.
module pnr_bus_master
  import pnr_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [15:0] cmd_burst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [31:0] sys_addr,
  output logic [31:0] sys_wdata,
  output logic        sys_wen,
  output logic        sys_ren,
  input  logic [31:0] sys_rdata,
  input  logic        sys_err,
  input  logic        sys_ack
);

  state_e      r_state;
  logic        r_we;
  logic [15:0] r_remaining;
  logic [31:0] r_sys_addr;
  logic [31:0] r_sys_wdata;
  logic        r_sys_wen;
  logic        r_sys_ren;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_rsp_last;
  logic        w_expired;

`ifdef PNR_BUS_TIMEOUT_EN
  pnr_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .i_clear  (r_state == STROBE),
    .i_start  (r_state == WAIT_ACK),
    .o_expired(w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 32'd1);
  assign w_expired        = 1'b0;
`endif

  // Held low while reset is asserted even though the state already reads IDLE.
  assign cmd_ready = (r_state == IDLE) && rstn_i;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign rsp_last  = r_rsp_last;
  assign sys_addr  = r_sys_addr;
  assign sys_wdata = r_sys_wdata;
  assign sys_wen   = r_sys_wen;
  assign sys_ren   = r_sys_ren;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_remaining <= '0;
      r_sys_addr  <= '0;
      r_sys_wdata <= '0;
      r_sys_wen   <= 1'b0;
      r_sys_ren   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_we        <= cmd_we;
            r_sys_addr  <= cmd_addr;
            r_sys_wdata <= cmd_wdata;
            r_remaining <= beat_count(cmd_we, cmd_burst);
            r_sys_wen   <= cmd_we;
            r_sys_ren   <= !cmd_we;
            r_state     <= STROBE;
          end
        end
        STROBE: begin
          r_sys_wen <= 1'b0;
          r_sys_ren <= 1'b0;
          r_state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (sys_ack) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= sys_err;
            r_rsp_data  <= (r_we || sys_err) ? 32'd0 : sys_rdata;
            r_rsp_last  <= sys_err || (r_remaining == 16'd1);
            r_state     <= RESP;
          end else if (w_expired) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_rsp_last  <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_state <= IDLE;
            end else begin
              // Next beat re-strobes the same address.
              r_remaining <= r_remaining - 16'd1;
              r_sys_wen   <= r_we;
              r_sys_ren   <= !r_we;
              r_state     <= STROBE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pnr_bus_master.sv
// Bench for pnr_bus_master: behavioural bus slave with a PNR FIFO, plus a reference
// model of expected responses built from the register map semantics.
module tb_pnr_bus_master;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [15:0] cmd_burst = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata = '0;
  logic        sys_err = 1'b0;
  logic        sys_ack = 1'b0;

  pnr_bus_master #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_burst(cmd_burst),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .rsp_last (rsp_last),
    .sys_addr (sys_addr),
    .sys_wdata(sys_wdata),
    .sys_wen  (sys_wen),
    .sys_ren  (sys_ren),
    .sys_rdata(sys_rdata),
    .sys_err  (sys_err),
    .sys_ack  (sys_ack)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  // ---------------- behavioural bus slave ----------------
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] slv_fifo [$];
  int          ack_delay = 1;
  bit          never_ack = 1'b0;
  bit          early_ack = 1'b0;
  bit          stray_ack = 1'b0;
  int          err_at = 0;
  int          strobe_cnt = 0;
  int          last_strobe_cyc = -1;
  int          viol = 0;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  logic        pend_err = 1'b0;
  logic [31:0] strobe_addr = '0;
  logic [31:0] strobe_wdata = '0;
  bit          prev_strobe = 1'b0;

  task automatic slave_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] q);
    q = 32'd0;
    if (we) begin
      if (a == 32'h70) slv_fifo.push_back(d);
      else if (a == 32'h78) slv_fifo.delete();
      else slv_mem[a] = d;
    end else begin
      if (a == 32'h70) begin
        if (slv_fifo.size() > 0) q = slv_fifo.pop_front();
      end else if (a == 32'h74) begin
        q = slv_fifo.size();
      end else if (slv_mem.exists(a)) begin
        q = slv_mem[a];
      end
    end
  endtask

  always @(posedge clk_i) begin
    bit acked;
    logic [31:0] q;
    #1;
    acked     = 1'b0;
    sys_ack   = 1'b0;
    sys_rdata = $urandom;
    sys_err   = 1'($urandom_range(0, 1));
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        acked     = 1'b1;
        sys_ack   = 1'b1;
        sys_rdata = pend_data;
        sys_err   = pend_err;
        if (sys_addr !== strobe_addr || sys_wdata !== strobe_wdata) viol++;
      end
    end
    if (sys_wen || sys_ren) begin
      if (sys_wen && sys_ren) viol++;
      if (prev_strobe) viol++;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      strobe_addr  = sys_addr;
      strobe_wdata = sys_wdata;
      if (!never_ack) begin
        pend_err = (strobe_cnt == err_at);
        if (pend_err) pend_data = 32'hDEAD_BEEF;
        else begin
          slave_access(sys_wen, sys_addr, sys_wdata, q);
          pend_data = q;
        end
        pend = ack_delay;
        if (early_ack) sys_ack = 1'b1;
      end
    end
    prev_strobe = sys_wen || sys_ren;
    if (stray_ack && !acked && pend == 0 && !prev_strobe) sys_ack = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_fifo [$];
  rsp_t        exp_q [$];
  rsp_t        got_q [$];
  int          got_cyc [$];

  task automatic model_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [15:0] b, input int err_beat);
    int beats;
    beats = (we || b == 16'd0) ? 1 : int'(b);
    for (int i = 1; i <= beats; i++) begin
      rsp_t r;
      r.data = 32'd0;
      r.err  = 1'b0;
      r.last = (i == beats);
      if (i == err_beat) begin
        r.err  = 1'b1;
        r.last = 1'b1;
        exp_q.push_back(r);
        break;
      end
      if (we) begin
        if (a == 32'h70) ref_fifo.push_back(d);
        else if (a == 32'h78) ref_fifo.delete();
        else ref_mem[a] = d;
      end else if (a == 32'h70) begin
        if (ref_fifo.size() > 0) r.data = ref_fifo.pop_front();
      end else if (a == 32'h74) begin
        r.data = ref_fifo.size();
      end else if (ref_mem.exists(a)) begin
        r.data = ref_mem[a];
      end
      exp_q.push_back(r);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [15:0] b, output int hs_cyc);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_burst = b;
    while (!cmd_ready && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    hs_cyc = cyc;
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk_i); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_we    = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int max_beats, input int budget, input bit rand_ready);
    int  n;
    bit  prev_v;
    bit  done;
    n = 0;
    prev_v = 1'b0;
    done = 1'b0;
    got_q.delete();
    got_cyc.delete();
    while (n < budget && !done) begin
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && !prev_v) got_cyc.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        got_q.push_back('{rsp_data, rsp_err, rsp_last});
        if (rsp_last || got_q.size() >= max_beats) done = 1'b1;
      end
      prev_v = rsp_valid;
      @(posedge clk_i); #1;
      n++;
    end
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn_i    = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({cmd_ready, sys_wen, sys_ren, rsp_valid, rsp_err, rsp_last} !== 6'b0 ||
        sys_addr !== 32'd0 || sys_wdata !== 32'd0 || rsp_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_values: rdy=%0b wen=%0b ren=%0b v=%0b e=%0b l=%0b a=%h wd=%h d=%h required all 0",
               cmd_ready, sys_wen, sys_ren, rsp_valid, rsp_err, rsp_last, sys_addr, sys_wdata,
               rsp_data);
    end
    rstn_i = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_readback();
    int hs;
    exp_q.delete();
    model_cmd(1'b1, 32'h24, 32'hA5A5_0001, 16'd3, 0);
    send_cmd(1'b1, 32'h24, 32'hA5A5_0001, 16'd3, hs);
    collect(4, 50, 1'b0);
    n_checks++;
    if (last_strobe_cyc != hs + 1) begin
      n_errors++;
      $display("FAIL wr_strobe_latency: strobe at %0d required %0d", last_strobe_cyc, hs + 1);
    end
    n_checks++;
    if (got_q.size() != 1 || got_cyc.size() < 1 || got_q[0] !== exp_q[0] ||
        got_cyc[0] != hs + 3) begin
      n_errors++;
      $display("FAIL wr_rsp: beats=%0d resp=%h required beats=1 resp=%h at cycle %0d",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0, exp_q[0], hs + 3);
    end
    exp_q.delete();
    model_cmd(1'b0, 32'h24, 32'd0, 16'd0, 0);
    send_cmd(1'b0, 32'h24, 32'd0, 16'd0, hs);
    collect(4, 50, 1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_errors++;
      $display("FAIL wr_readback: beats=%0d resp=%h required beats=1 resp=%h", got_q.size(),
               got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_fifo_burst();
    int hs;
    int s0;
    logic [31:0] vals [4];
    vals = '{32'd10, 32'd11, 32'd12, 32'd13};
    exp_q.delete();
    model_cmd(1'b1, 32'h78, 32'd0, 16'd0, 0);
    send_cmd(1'b1, 32'h78, 32'd0, 16'd0, hs);
    collect(1, 50, 1'b0);
    for (int i = 0; i < 4; i++) begin
      model_cmd(1'b1, 32'h70, vals[i], 16'd0, 0);
      send_cmd(1'b1, 32'h70, vals[i], 16'd0, hs);
      collect(1, 50, 1'b0);
    end
    exp_q.delete();
    model_cmd(1'b0, 32'h70, 32'd0, 16'd4, 0);
    send_cmd(1'b0, 32'h70, 32'd0, 16'd4, hs);
    collect(8, 100, 1'b0);
    n_checks++;
    if (got_q.size() != 4) begin
      n_errors++;
      $display("FAIL fifo_burst_beats: got %0d required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_q[i].data !== vals[i]) begin
        n_errors++;
        $display("FAIL fifo_burst[%0d]: resp=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_checks++;
      if (got_cyc[i] - got_cyc[i-1] != 3) begin
        n_errors++;
        $display("FAIL burst_spacing[%0d]: %0d cycles required 3", i,
                 got_cyc[i] - got_cyc[i-1]);
      end
    end
    exp_q.delete();
    model_cmd(1'b0, 32'h74, 32'd0, 16'd0, 0);
    send_cmd(1'b0, 32'h74, 32'd0, 16'd0, hs);
    collect(4, 50, 1'b0);
    s0 = strobe_cnt;
    repeat (10) @(posedge clk_i);
    #1;
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || exp_q[0].data !== 32'd0 ||
        strobe_cnt != s0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL burst0_count: beats=%0d resp=%h extra_strobes=%0d required beats=1 resp=%h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0, strobe_cnt - s0, exp_q[0]);
    end
  endtask

  task automatic test_error_abort();
    int hs;
    int s0;
    exp_q.delete();
    model_cmd(1'b1, 32'h78, 32'd0, 16'd0, 0);
    send_cmd(1'b1, 32'h78, 32'd0, 16'd0, hs);
    collect(1, 50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] v;
      v = $urandom;
      model_cmd(1'b1, 32'h70, v, 16'd0, 0);
      send_cmd(1'b1, 32'h70, v, 16'd0, hs);
      collect(1, 50, 1'b0);
    end
    exp_q.delete();
    model_cmd(1'b0, 32'h70, 32'd0, 16'd5, 2);
    s0 = strobe_cnt;
    err_at = strobe_cnt + 2;
    send_cmd(1'b0, 32'h70, 32'd0, 16'd5, hs);
    collect(8, 100, 1'b0);
    repeat (10) @(posedge clk_i);
    #1;
    err_at = 0;
    n_checks++;
    if (got_q.size() != 2 || strobe_cnt - s0 != 2) begin
      n_errors++;
      $display("FAIL err_abort: beats=%0d strobes=%0d required beats=2 strobes=2",
               got_q.size(), strobe_cnt - s0);
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL err_beat[%0d]: resp=%h required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    model_cmd(1'b0, 32'h74, 32'd0, 16'd0, 0);
    send_cmd(1'b0, 32'h74, 32'd0, 16'd0, hs);
    collect(1, 50, 1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_errors++;
      $display("FAIL err_fifo_count: resp=%h required %h", got_q.size() > 0 ? got_q[0] : '0,
               exp_q[0]);
    end
  endtask

  task automatic test_stall();
    int   hs;
    int   n;
    int   s0;
    rsp_t held;
    exp_q.delete();
    model_cmd(1'b0, 32'h24, 32'd0, 16'd0, 0);
    rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h24, 32'd0, 16'd0, hs);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    held = '{rsp_data, rsp_err, rsp_last};
    s0 = strobe_cnt;
    stray_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_err, rsp_last} !== {1'b1, held}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: v=%0b resp=%h required v=1 resp=%h", i, rsp_valid,
                 {rsp_data, rsp_err, rsp_last}, held);
      end
    end
    stray_ack = 1'b0;
    n_checks++;
    if (held !== exp_q[0] || strobe_cnt != s0) begin
      n_errors++;
      $display("FAIL stall_rsp: resp=%h strobes=%0d required resp=%h strobes=0", held,
               strobe_cnt - s0, exp_q[0]);
    end
    rsp_ready = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || strobe_cnt != s0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: v=%0b strobes=%0d rdy=%0b required v=0 strobes=0 rdy=1",
               rsp_valid, strobe_cnt - s0, cmd_ready);
    end
  endtask

  task automatic test_early_ack();
    int hs;
    exp_q.delete();
    model_cmd(1'b0, 32'h24, 32'd0, 16'd2, 0);
    early_ack = 1'b1;
    send_cmd(1'b0, 32'h24, 32'd0, 16'd2, hs);
    collect(4, 60, 1'b0);
    early_ack = 1'b0;
    n_checks++;
    if (got_q.size() != 2 || got_cyc.size() < 2 || got_cyc[0] != hs + 3 ||
        got_cyc[1] != hs + 6 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      n_errors++;
      $display("FAIL early_ack: beats=%0d first_valid=%0d required beats=2 first_valid=%0d",
               got_q.size(), got_cyc.size() > 0 ? got_cyc[0] : -1, hs + 3);
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [7];
    addrs = '{32'h20, 32'h24, 32'h28, 32'h3C, 32'h70, 32'h74, 32'h78};
    for (int k = 0; k < 40; k++) begin
      int          hs;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [15:0] b;
      we = 1'($urandom_range(0, 1));
      a  = addrs[$urandom_range(0, 6)];
      d  = $urandom;
      b  = 16'($urandom_range(0, 5));
      ack_delay = $urandom_range(1, 3);
      exp_q.delete();
      model_cmd(we, a, d, b, 0);
      send_cmd(we, a, d, b, hs);
      collect(exp_q.size() + 2, 400, 1'b1);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_errors++;
        $display("FAIL rand[%0d] beats: got %0d required %0d", k, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL rand[%0d] beat %0d: resp=%h required %h (we=%0b a=%h b=%0d)", k, i,
                   got_q[i], exp_q[i], we, a, b);
        end
      end
    end
    ack_delay = 1;
  endtask

  task automatic test_timeout();
    int hs;
    never_ack = 1'b1;
    send_cmd(1'b0, 32'h30, 32'd0, 16'd3, hs);
`ifdef PNR_BUS_TIMEOUT_EN
    collect(4, 40, 1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_cyc.size() < 1 || got_q[0] !== {32'd0, 1'b1, 1'b1} ||
        got_cyc[0] != hs + 1 + 9) begin
      n_errors++;
      $display("FAIL timeout_rsp: beats=%0d resp=%h at %0d required beats=1 resp=%h at %0d",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0,
               got_cyc.size() > 0 ? got_cyc[0] : -1, {32'd0, 1'b1, 1'b1}, hs + 10);
    end
    send_cmd(1'b0, 32'h30, 32'd0, 16'd0, hs);
`else
    collect(4, 40, 1'b0);
    n_checks++;
    if (got_q.size() != 0) begin
      n_errors++;
      $display("FAIL no_timeout: beats=%0d required 0", got_q.size());
    end
`endif
  endtask

  task automatic test_reset_mid();
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    #2;
    n_checks++;
    if ({cmd_ready, sys_wen, sys_ren, rsp_valid, rsp_err, rsp_last} !== 6'b0 ||
        sys_addr !== 32'd0 || sys_wdata !== 32'd0 || rsp_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_values: rdy=%0b wen=%0b ren=%0b v=%0b a=%h required all 0",
               cmd_ready, sys_wen, sys_ren, rsp_valid, sys_addr);
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    #1;
    never_ack = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    collect(1, 15, 1'b0);
    n_checks++;
    if (got_q.size() != 0) begin
      n_errors++;
      $display("FAIL reset_mid_abandon: beats=%0d required 0", got_q.size());
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol != 0) begin
      n_errors++;
      $display("FAIL strobe_protocol: violations=%0d required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_fifo_burst();
    test_error_abort();
    test_stall();
    test_early_ack();
    test_random();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
